// File: rtl/dffe_pipe.sv
// Enabled register pipeline with per-stage valid bits, synchronous flush and a
// registered occupancy count of the valid stages.
module dffe_pipe #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned     OCC_W     = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             out_valid,
   output logic [OCC_W-1:0] occupancy
);

   localparam int unsigned LAST = STAGES - 1;

   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] valid_q, valid_d;
   logic [OCC_W-1:0]  occ_q, occ_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      occ_d   = occ_q;
      if (flush) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            data_d[k] = RESET_VAL;
         end
         valid_d = '0;
         occ_d   = '0;
      end else if (en) begin
         data_d[0]  = d;
         valid_d[0] = in_valid;
         // Data shifts regardless of valid; consumers qualify with out_valid.
         for (int k = 1; k < int'(STAGES); k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         // One word in and/or one word out per advance, so +-1 tracks popcount.
         if (in_valid && !valid_q[LAST]) begin
            occ_d = occ_q + OCC_W'(1);
         end else if (!in_valid && valid_q[LAST]) begin
            occ_d = occ_q - OCC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            data_q[k] <= RESET_VAL;
         end
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   assign q         = data_q[LAST];
   assign out_valid = valid_q[LAST];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_dffe_pipe.sv
// Directed bench for dffe_pipe: a WIDTH=8/STAGES=3 instance and a
// WIDTH=1/STAGES=1/RESET_VAL=1 instance driven from one linear sequence.
module tb_dffe_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: WIDTH=8, STAGES=3, RESET_VAL=0
   logic       clr_n_a, en_a, flush_a, in_valid_a;
   logic [7:0] d_a, q_a;
   logic       out_valid_a;
   logic [1:0] occ_a;

   dffe_pipe #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00)) u_dut_a (
      .clk       (clk),
      .clr_n     (clr_n_a),
      .en        (en_a),
      .flush     (flush_a),
      .in_valid  (in_valid_a),
      .d         (d_a),
      .q         (q_a),
      .out_valid (out_valid_a),
      .occupancy (occ_a)
   );

   // Instance B: WIDTH=1, STAGES=1, RESET_VAL=1
   logic clr_n_b, en_b, flush_b, in_valid_b;
   logic d_b, q_b, out_valid_b;
   logic occ_b;

   dffe_pipe #(.WIDTH(1), .STAGES(1), .RESET_VAL(1'b1)) u_dut_b (
      .clk       (clk),
      .clr_n     (clr_n_b),
      .en        (en_b),
      .flush     (flush_b),
      .in_valid  (in_valid_b),
      .d         (d_b),
      .q         (q_b),
      .out_valid (out_valid_b),
      .occupancy (occ_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [7:0] eq, input logic ev,
                        input logic [1:0] eo);
      chk({tag, ".q"}, 64'(q_a), 64'(eq));
      chk({tag, ".out_valid"}, 64'(out_valid_a), 64'(ev));
      chk({tag, ".occupancy"}, 64'(occ_a), 64'(eo));
   endtask

   task automatic chk_b(input string tag, input logic eq, input logic ev, input logic eo);
      chk({tag, ".q"}, 64'(q_b), 64'(eq));
      chk({tag, ".out_valid"}, 64'(out_valid_b), 64'(ev));
      chk({tag, ".occupancy"}, 64'(occ_b), 64'(eo));
   endtask

   // Inputs change and outputs are sampled 2 time units after each rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_a(input logic e, input logic f, input logic v, input logic [7:0] dv);
      en_a = e; flush_a = f; in_valid_a = v; d_a = dv;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr_n_a = 1'b0; clr_n_b = 1'b0;
      drive_a(1'b0, 1'b0, 1'b0, 8'h00);
      en_b = 1'b0; flush_b = 1'b0; in_valid_b = 1'b0; d_b = 1'b0;

      #12;
      chk_a("reset_a", 8'h00, 1'b0, 2'd0);
      chk_b("reset_b", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      clr_n_a = 1'b1;

      // Fill: 0x11, 0x22, 0x33
      drive_a(1'b1, 1'b0, 1'b1, 8'h11); tick(); chk_a("fill1", 8'h00, 1'b0, 2'd1);
      drive_a(1'b1, 1'b0, 1'b1, 8'h22); tick(); chk_a("fill2", 8'h00, 1'b0, 2'd2);
      drive_a(1'b1, 1'b0, 1'b1, 8'h33); tick(); chk_a("fill3", 8'h11, 1'b1, 2'd3);

      // Stall five cycles with a valid word presented
      drive_a(1'b0, 1'b0, 1'b1, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         tick(); chk_a("stall", 8'h11, 1'b1, 2'd3);
      end

      // Resume: order preserved, full pipe keeps occupancy
      drive_a(1'b1, 1'b0, 1'b1, 8'h44); tick(); chk_a("resume1", 8'h22, 1'b1, 2'd3);
      drive_a(1'b1, 1'b0, 1'b1, 8'h55); tick(); chk_a("resume2", 8'h33, 1'b1, 2'd3);

      // Flush with en=1 and a valid word: that word is discarded
      drive_a(1'b1, 1'b1, 1'b1, 8'hAA); tick(); chk_a("flush", 8'h00, 1'b0, 2'd0);
      drive_a(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick(); chk_a("post_flush", 8'h00, 1'b0, 2'd0);
      end

      // in_valid 1,0,1,1 then 0
      drive_a(1'b1, 1'b0, 1'b1, 8'hA1); tick(); chk_a("pat1", 8'h00, 1'b0, 2'd1);
      drive_a(1'b1, 1'b0, 1'b0, 8'hA2); tick(); chk_a("pat2", 8'h00, 1'b0, 2'd1);
      drive_a(1'b1, 1'b0, 1'b1, 8'hA3); tick(); chk_a("pat3", 8'hA1, 1'b1, 2'd2);
      drive_a(1'b1, 1'b0, 1'b1, 8'hA4); tick(); chk_a("pat4", 8'hA2, 1'b0, 2'd2);
      drive_a(1'b1, 1'b0, 1'b0, 8'h00); tick(); chk_a("pat5", 8'hA3, 1'b1, 2'd2);

      // Refill to full, then asynchronous reset between edges
      drive_a(1'b1, 1'b1, 1'b0, 8'h00); tick(); chk_a("flush2", 8'h00, 1'b0, 2'd0);
      drive_a(1'b1, 1'b0, 1'b1, 8'hC1); tick();
      drive_a(1'b1, 1'b0, 1'b1, 8'hC2); tick();
      drive_a(1'b1, 1'b0, 1'b1, 8'hC3); tick(); chk_a("refill", 8'hC1, 1'b1, 2'd3);
      clr_n_a = 1'b0;
      #1;
      chk_a("async_rst", 8'h00, 1'b0, 2'd0);
      // Inputs ignored while held in reset across an edge
      drive_a(1'b1, 1'b0, 1'b1, 8'hEE); tick(); chk_a("rst_hold", 8'h00, 1'b0, 2'd0);
      @(negedge clk);
      clr_n_a = 1'b1;
      drive_a(1'b1, 1'b0, 1'b1, 8'hD1); tick(); chk_a("post_rst1", 8'h00, 1'b0, 2'd1);
      drive_a(1'b1, 1'b0, 1'b0, 8'h00); tick(); chk_a("post_rst2", 8'h00, 1'b0, 2'd1);
      tick(); chk_a("post_rst3", 8'hD1, 1'b1, 2'd1);
      tick(); chk_a("post_rst4", 8'h00, 1'b0, 2'd0);

      // Single-stage instance
      @(negedge clk);
      clr_n_b = 1'b1;
      en_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b1; d_b = 1'b0;
      tick(); chk_b("b_load", 1'b0, 1'b1, 1'b1);
      en_b = 1'b0; in_valid_b = 1'b1; d_b = 1'b1;
      tick(); chk_b("b_hold", 1'b0, 1'b1, 1'b1);
      en_b = 1'b0; flush_b = 1'b1; in_valid_b = 1'b1; d_b = 1'b0;
      tick(); chk_b("b_flush", 1'b1, 1'b0, 1'b0);
      en_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; d_b = 1'b0;
      tick(); chk_b("b_invalid_shift", 1'b0, 1'b0, 1'b0);
      en_b = 1'b1; in_valid_b = 1'b1; d_b = 1'b1;
      tick(); chk_b("b_load2", 1'b1, 1'b1, 1'b1);
      en_b = 1'b1; in_valid_b = 1'b0; d_b = 1'b0;
      tick(); chk_b("b_drain", 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dffe_pipe.md
DFFE_PIPE -- requirements
Module: dffe_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data bits per stage; legal range 1..64.
REQ-002 Parameter STAGES, default 2: number of register stages; legal range 1..16.
REQ-003 Parameter RESET_VAL, default 0: value loaded into every stage data register on reset and on flush; WIDTH bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  advance enable; 1 shifts the pipe one stage, 0 holds every stage.
REQ-007 flush  input  1  synchronous clear of all stages.
REQ-008 in_valid  input  1  qualifies d for entry into stage 0.
REQ-009 d  input  WIDTH  data into stage 0.
REQ-010 q  output  WIDTH  data of the last stage (STAGES-1), driven directly from a register.
REQ-011 out_valid  output  1  valid bit of the last stage.
REQ-012 occupancy  output  clog2(STAGES+1)  number of stages whose valid bit is 1.

Function
REQ-013 Each stage k SHALL hold a WIDTH-bit data register and a 1-bit valid register.
REQ-014 When clr_n=1, flush=0 and en=1 on a rising edge: stage 0 SHALL load d and in_valid, and stage k (k>=1) SHALL load stage k-1 data and valid.
REQ-015 When clr_n=1, flush=0 and en=0: every data and valid register SHALL hold its value, regardless of in_valid.
REQ-016 Data registers SHALL shift on en=1 even when the corresponding valid is 0; consumers qualify q with out_valid only.
REQ-017 When clr_n=1 and flush=1 on a rising edge: every valid SHALL become 0 and every data register SHALL become RESET_VAL, regardless of en and in_valid.
REQ-018 flush SHALL take priority over en; d presented in the flush cycle SHALL be discarded.
REQ-019 Latency: with en held 1, a word sampled on edge N SHALL appear on q/out_valid after edge N+STAGES-1, i.e. STAGES rising edges after the word is presented at d.
REQ-020 With STAGES=1, the block SHALL behave as a single WIDTH-bit enabled register with sync clear plus a valid bit.
REQ-021 A stall (en=0) of any length SHALL NOT lose, duplicate or reorder words; order out SHALL equal order in.
REQ-022 occupancy SHALL be a registered value, updated on the same edge as the valid bits, equal to the popcount of the valid bits after that edge; range 0..STAGES, never wraps.
REQ-023 occupancy update on en=1: +1 if in_valid=1 and last-stage valid=0; -1 if in_valid=0 and last-stage valid=1; unchanged otherwise.
REQ-024 occupancy SHALL become 0 on flush and hold on en=0.
REQ-025 No combinational path SHALL exist from any input to q, out_valid or occupancy.

Reset
REQ-026 clr_n=0 SHALL immediately, without waiting for clk, force all data registers to RESET_VAL, all valid bits to 0 and occupancy to 0.
REQ-027 While clr_n=0, en, flush, in_valid and d SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight words; after clr_n rises, the first edge with en=1 SHALL accept new data normally.
REQ-029 Power-up state before the first reset is not guaranteed; the bench SHALL apply clr_n=0 first.

Verification
REQ-030 WIDTH=8, STAGES=3: reset, then en=1, in_valid=1, d=0x11,0x22,0x33 on three consecutive edges -> q=0x11 with out_valid=1 after the third edge, occupancy=3.
REQ-031 Same config, pipe full, en=0 for 5 cycles with d=0xFF, in_valid=1 -> q, out_valid and occupancy hold (0x11/1/3); en=1 resumes with 0x22 next.
REQ-032 Pipe holding 3 valid words, flush=1 and en=1 on one edge -> out_valid=0, occupancy=0, q=RESET_VAL; d in that cycle never appears on q.
REQ-033 clr_n pulsed low between clock edges with pipe full -> q=RESET_VAL, out_valid=0, occupancy=0 before the next rising edge.
REQ-034 in_valid pattern 1,0,1 with en=1 and STAGES=3 -> out_valid pattern 1,0,1 starting after the third edge; occupancy sequence 1,1,2,2.
REQ-035 STAGES=1, WIDTH=1, RESET_VAL=1: reset -> q=1; en=1, d=0 -> q=0 after one edge; flush=1 -> q=1, out_valid=0.
